affine3_acc: RTL and testbench
==============================

# affine3_acc

Output stage of affine3, directly downstream of the 16-input second-stage adder. Each adder result is a 14-bit signed partial sum covering 16 products. This block accumulates NUM_GROUPS consecutive partial sums into one neuron pre-activation and adds a per-neuron bias. It then applies ReLU, right-shift scaling and unsigned saturation, and presents the activation on a valid/ready output port.

## Interface
- NUM_GROUPS, 4: partial sums per neuron; range 1..16
- IN_WIDTH, 14: partial-sum width, signed two's complement
- ACC_WIDTH, 20: accumulator and bias width, signed; must be ≥ IN_WIDTH + clog2(NUM_GROUPS) + 1
- SHIFT, 4: right-shift scaling before saturation; range 1..ACC_WIDTH-1
- OUT_WIDTH, 8: activation width, unsigned
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  data_in carries a partial sum
- in_ready  out  1  block accepts a partial sum this cycle
- data_in  in  IN_WIDTH  partial sum from the second-stage adder
- bias_in  in  ACC_WIDTH  neuron bias; sampled with the first partial sum of each neuron
- out_valid  out  1  data_out and sat_out are valid
- out_ready  in  1  downstream consumes the result
- data_out  out  OUT_WIDTH  activation
- sat_out  out  1  the result was clamped to the maximum value

## Operation
- States:
  - ACC: accepting partial sums.
  - POST: one cycle of post-processing.
  - OUT: holding the result.
- A beat is accepted when in_valid && in_ready. in_ready = (state == ACC).
- Group counter cnt runs 0..NUM_GROUPS-1.
  - Beat with cnt == 0: acc ← bias_in + sext(data_in).
  - Any other beat: acc ← acc + sext(data_in).
- Accumulation wraps modulo 2^ACC_WIDTH. No overflow detection. The parameter rule above prevents wrap for in-range bias.
- Beat with cnt == NUM_GROUPS-1: cnt ← 0, state → POST.
- POST computes the result:
  - acc < 0: data_out ← 0, sat_out ← 0.
  - Otherwise v = acc >> SHIFT (arithmetic shift).
  - v > 2^OUT_WIDTH-1: data_out ← all ones, sat_out ← 1.
  - Else data_out ← v[OUT_WIDTH-1:0], sat_out ← 0.
  - State → OUT.
- OUT: out_valid = 1. data_out and sat_out stay stable until the handshake. On out_ready, state → ACC.
- in_valid is ignored outside ACC. Data presented then is not consumed and not lost; upstream holds it per the handshake.
- Reset values:
  - state = ACC, cnt = 0, acc = 0
  - in_ready = 1 (from the first cycle after reset is released)
  - out_valid = 0, data_out = 0, sat_out = 0
- Reset during any state discards the partial accumulation and any pending result. The next accepted beat is treated as cnt == 0.
- NUM_GROUPS = 1: every accepted beat goes straight to POST.

## Timing
- Last beat accepted at edge t. POST occupies cycle t+1. out_valid is high from edge t+2.
- Result handshake at edge u: the block is in ACC from edge u and in_ready = 1 in that cycle. There is no bubble beyond that.
- Throughput is one neuron per NUM_GROUPS + 2 cycles with no backpressure.
- in_ready and out_valid are registered state decodes. There is no combinational path from in_valid or out_ready to any output.
- out_ready asserted while out_valid = 0 has no effect.

## Configuration
- AFFINE3_ACC_ROUND_EN defined: POST uses v = (acc + 2^(SHIFT-1)) >> SHIFT, i.e. round half up. The ReLU test still uses the unrounded acc. The rounding add is ACC_WIDTH+1 bits wide and cannot wrap.
- Undefined: v = acc >> SHIFT (truncation). No rounding adder is built.

## Test plan
Settings: NUM_GROUPS=4, SHIFT=4, OUT_WIDTH=8, ACC_WIDTH=20.
- Basic: bias 0, beats 16, 32, 48, 64 -> data_out = 10, sat_out = 0. out_valid rises 2 cycles after the 4th accept.
- ReLU: bias 0, four beats of -100 (0x3F9C) -> data_out = 0, sat_out = 0. Repeat with bias 500 and the same beats (acc = 100) -> data_out = 6.
- Saturation: bias 0, four beats of 8191 -> acc = 32764, data_out = 255, sat_out = 1.
- Rounding: bias 0, beats 24, 0, 0, 0 -> data_out = 2 with AFFINE3_ACC_ROUND_EN defined, 1 without.
- Backpressure: hold out_ready low 5 cycles after out_valid. data_out and out_valid stay stable and in_ready stays 0. in_valid pulses in that window are not accepted. Raising out_ready gives one handshake, then in_ready = 1 in the following cycle.
- Reset mid-neuron: accept 2 beats of 1000, then pulse reset, then send bias 0 and beats 16, 32, 48, 64 -> data_out = 10. Outputs read 0 and in_ready reads 1 in the cycle after reset.

Source files
------------

// File: rtl/affine3_acc.sv
// ---------------------------------------------------------------------------
// affine3_acc
//
// Output stage of affine3. Accumulates NUM_GROUPS signed partial sums from the
// second-stage adder into one neuron pre-activation. The per-neuron bias is
// sampled with the first partial sum. The block then applies ReLU,
// right-shift scaling and unsigned saturation, and holds the activation on a
// valid/ready output port.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   data_in carries a partial sum
//   in_ready   out  block accepts a partial sum this cycle (state == ACC)
//   data_in    in   IN_WIDTH signed partial sum
//   bias_in    in   ACC_WIDTH signed bias, sampled with the first beat
//   out_valid  out  data_out / sat_out hold a result (state == OUT)
//   out_ready  in   downstream consumes the result
//   data_out   out  OUT_WIDTH unsigned activation
//   sat_out    out  result was clamped to the maximum value
//
// Configuration macro:
//   AFFINE3_ACC_ROUND_EN  when defined, post-processing rounds half up before
//                         the shift; otherwise the shift truncates.
// ---------------------------------------------------------------------------
module affine3_acc #(
  parameter int NUM_GROUPS = 4,
  parameter int IN_WIDTH   = 14,
  parameter int ACC_WIDTH  = 20,
  parameter int SHIFT      = 4,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic [ACC_WIDTH-1:0] bias_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 sat_out
);

  localparam int CNT_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_GROUPS - 1);

  // Post-processing runs one bit wider than the accumulator so that the
  // optional rounding add can never wrap.
  localparam int VW = ACC_WIDTH + 1;
  localparam logic [VW+OUT_WIDTH-1:0] MAX_V = {{VW{1'b0}}, {OUT_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    ST_ACC,
    ST_POST,
    ST_OUT
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]     cnt;
  logic [ACC_WIDTH-1:0] acc;

  logic                 in_fire;
  logic                 last_beat;
  logic [ACC_WIDTH-1:0] data_sext;
  logic [ACC_WIDTH-1:0] acc_base;

  logic [VW-1:0]           acc_ext;
  logic [VW-1:0]           pre_shift;
  logic [VW-1:0]           shifted;
  logic [VW+OUT_WIDTH-1:0] v_wide;
  logic                    acc_neg;
  logic                    post_sat;
  logic [OUT_WIDTH-1:0]    post_data;

  // Handshake outputs are pure decodes of the registered state, so there is
  // no combinational path from in_valid/out_ready to any output.
  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_OUT);

  assign in_fire   = in_valid && (state == ST_ACC);
  assign last_beat = (cnt == CNT_LAST);

  // The first beat of a neuron starts from the bias instead of the running
  // sum; the add wraps modulo 2^ACC_WIDTH.
  assign data_sext = {{(ACC_WIDTH - IN_WIDTH){data_in[IN_WIDTH-1]}}, data_in};
  assign acc_base  = (cnt == '0) ? bias_in : acc;

  assign acc_neg = acc[ACC_WIDTH-1];
  assign acc_ext = {acc[ACC_WIDTH-1], acc};

`ifdef AFFINE3_ACC_ROUND_EN
  localparam logic [VW-1:0] RND_CONST = VW'(1) << (SHIFT - 1);
  assign pre_shift = acc_ext + RND_CONST;
`else
  assign pre_shift = acc_ext;
`endif

  // ReLU uses the unrounded sign, so the shifted value is only consumed when
  // it is non-negative; the zero-extended compare then detects saturation.
  assign shifted   = VW'($signed(pre_shift) >>> SHIFT);
  assign v_wide    = {{OUT_WIDTH{1'b0}}, shifted};
  assign post_sat  = !acc_neg && (v_wide > MAX_V);
  assign post_data = acc_neg  ? '0 :
                     post_sat ? '1 :
                     v_wide[OUT_WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_ACC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_ACC:  if (in_fire && last_beat) state_next = ST_POST;
      ST_POST: state_next = ST_OUT;
      ST_OUT:  if (out_ready) state_next = ST_ACC;
      default: state_next = ST_ACC;
    endcase
  end

  // Result registers load only in POST and therefore stay stable through the
  // whole OUT hold, however long downstream stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      data_out <= '0;
      sat_out  <= 1'b0;
    end else begin
      if (in_fire) begin
        acc <= acc_base + data_sext;
        cnt <= last_beat ? '0 : cnt + CNT_W'(1);
      end
      if (state == ST_POST) begin
        data_out <= post_data;
        sat_out  <= post_sat;
      end
    end
  end

endmodule

// File: tb/tb_affine3_acc.sv
// ---------------------------------------------------------------------------
// tb_affine3_acc
//
// Directed scenarios followed by randomized neurons for affine3_acc. Expected
// activations come from an integer reference model of the neuron arithmetic.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_affine3_acc;

  localparam int NUM_GROUPS = 4;
  localparam int IN_WIDTH   = 14;
  localparam int ACC_WIDTH  = 20;
  localparam int SHIFT      = 4;
  localparam int OUT_WIDTH  = 8;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  data_in;
  logic [ACC_WIDTH-1:0] bias_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] data_out;
  logic                 sat_out;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  affine3_acc #(
    .NUM_GROUPS(NUM_GROUPS),
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .bias_in  (bias_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .sat_out  (sat_out)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Neuron arithmetic at integer level: sum, wrap to the accumulator width,
  // ReLU, scale by division, clamp.
  function automatic void model(input int bias, input int beats[NUM_GROUPS],
                                output int exp_data, output int exp_sat);
    longint sum;
    logic signed [ACC_WIDTH-1:0] acc;
    longint v;
    sum = bias;
    for (int i = 0; i < NUM_GROUPS; i++) sum += beats[i];
    acc = ACC_WIDTH'(sum);
    exp_data = 0;
    exp_sat  = 0;
    if (acc >= 0) begin
`ifdef AFFINE3_ACC_ROUND_EN
      v = (longint'(acc) + (64'sd1 <<< (SHIFT - 1))) / (64'sd1 <<< SHIFT);
`else
      v = longint'(acc) / (64'sd1 <<< SHIFT);
`endif
      if (v > (2 ** OUT_WIDTH) - 1) begin
        exp_data = (2 ** OUT_WIDTH) - 1;
        exp_sat  = 1;
      end else begin
        exp_data = int'(v);
      end
    end
  endfunction

  // Sends one neuron; bias is meaningful only on the first beat, later beats
  // carry random bias values that must be ignored. Returns on the falling
  // edge right after the last beat was accepted.
  task automatic apply_stimulus(input int bias, input int beats[NUM_GROUPS],
                                input int gap_max);
    int wait_cnt;
    for (int i = 0; i < NUM_GROUPS; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        data_in  = IN_WIDTH'($urandom);
        @(negedge clock);
      end
      in_valid = 1'b1;
      data_in  = IN_WIDTH'(beats[i]);
      bias_in  = (i == 0) ? ACC_WIDTH'(bias) : ACC_WIDTH'($urandom);
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 50) begin
        @(negedge clock);
        wait_cnt++;
      end
      check_output("in_ready_timeout", (wait_cnt < 50), 1);
      @(negedge clock);
    end
    in_valid = 1'b0;
  endtask

  // Checks the POST bubble, the result, an optional stall with ignored
  // in_valid pulses, then the handshake and the return to ACC.
  task automatic expect_result(input string tag, input int exp_data,
                               input int exp_sat, input int stall);
    check_output({tag, "_post_valid"}, out_valid, 0);
    @(negedge clock);
    check_output({tag, "_out_valid"}, out_valid, 1);
    check_output({tag, "_data"}, data_out, exp_data);
    check_output({tag, "_sat"}, sat_out, exp_sat);
    check_output({tag, "_in_ready_out"}, in_ready, 0);
    for (int s = 0; s < stall; s++) begin
      in_valid = s[0];
      data_in  = IN_WIDTH'(77);
      @(negedge clock);
      check_output({tag, "_stall_data"}, data_out, exp_data);
      check_output({tag, "_stall_valid"}, out_valid, 1);
      check_output({tag, "_stall_in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check_output({tag, "_after_hs_valid"}, out_valid, 0);
    check_output({tag, "_after_hs_ready"}, in_ready, 1);
  endtask

  initial begin
    int beats[NUM_GROUPS];
    int exp_data;
    int exp_sat;
    int bias;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    bias_in   = '0;
    repeat (3) @(negedge clock);
    check_output("reset_in_ready", in_ready, 1);
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_data", data_out, 0);
    check_output("reset_sat", sat_out, 0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] basic accumulation");
    beats = '{16, 32, 48, 64};
    apply_stimulus(0, beats, 0);
    expect_result("basic", 10, 0, 0);

    $display("[TB] relu");
    beats = '{-100, -100, -100, -100};
    apply_stimulus(0, beats, 0);
    expect_result("relu_neg", 0, 0, 0);
    apply_stimulus(500, beats, 0);
    expect_result("relu_bias", 6, 0, 0);

    $display("[TB] saturation");
    beats = '{8191, 8191, 8191, 8191};
    apply_stimulus(0, beats, 0);
    expect_result("sat", 255, 1, 0);

    $display("[TB] rounding");
    beats = '{24, 0, 0, 0};
    apply_stimulus(0, beats, 0);
`ifdef AFFINE3_ACC_ROUND_EN
    expect_result("round", 2, 0, 0);
`else
    expect_result("round", 1, 0, 0);
`endif

    $display("[TB] backpressure");
    beats = '{100, 200, 300, 400};
    apply_stimulus(0, beats, 0);
    expect_result("bp", 62, 0, 5);
    beats = '{16, 32, 48, 64};
    apply_stimulus(0, beats, 0);
    expect_result("bp_next", 10, 0, 0);

    $display("[TB] reset mid-neuron");
    in_valid = 1'b1;
    bias_in  = '0;
    data_in  = IN_WIDTH'(1000);
    @(negedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    check_output("midrst_in_ready", in_ready, 1);
    check_output("midrst_out_valid", out_valid, 0);
    check_output("midrst_data", data_out, 0);
    check_output("midrst_sat", sat_out, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    beats = '{16, 32, 48, 64};
    apply_stimulus(0, beats, 1);
    out_ready = 1'b0;
    expect_result("midrst", 10, 0, 0);

    $display("[TB] randomized neurons");
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NUM_GROUPS; i++)
        beats[i] = int'($urandom_range(0, 16383)) - 8192;
      if (n % 3 == 0)
        bias = int'($urandom_range(0, 1048575)) - 524288;
      else
        bias = int'($urandom_range(0, 8191)) - 2048;
      model(bias, beats, exp_data, exp_sat);
      apply_stimulus(bias, beats, 2);
      expect_result($sformatf("rand%0d", n), exp_data, exp_sat,
                    int'($urandom_range(0, 3)));
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
